// File: rtl/lpf_window_integrator.sv
// lpf_window_integrator
//   Windowed sample summer used as a boxcar low-pass / matched filter.
//   MODE 0: sliding moving sum over the last WINDOW samples (circular buffer
//           plus running sum, FILL until the first full window, then RUN).
//   MODE 1: integrate-and-dump; one result per WINDOW accepted samples.
//
// Ports
//   clk        : clock, all state updates on rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_data carries a sample this cycle
//   in_data    : signed sample, DATA_WIDTH bits
//   sym_start  : discard the partial window, restart alignment
//   clear      : synchronous flush of all state (overrides everything)
//   out_valid  : one-cycle pulse, out_data holds a new sum
//   out_data   : signed registered sum, OUT_WIDTH bits, held between pulses
module lpf_window_integrator #(
    parameter  int DATA_WIDTH = 18,
    parameter  int WINDOW     = 8,
    parameter  int MODE       = 0,
    localparam int LOG2W      = $clog2(WINDOW),
    localparam int OUT_WIDTH  = DATA_WIDTH + LOG2W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                        sym_start,
    input  logic                        clear,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out_data
);

    typedef enum logic {FILL, RUN} state_t;

    state_t                       state_q, state_d, state_base;
    logic [LOG2W-1:0]             cnt_q, cnt_d, cnt_base;
    logic signed [OUT_WIDTH-1:0]  sum_q, sum_d, sum_base;
    logic signed [OUT_WIDTH-1:0]  sample_ext, oldest_ext, sum_new;
    logic signed [OUT_WIDTH-1:0]  out_data_d;
    logic                         out_valid_d;
    logic                         last;
    logic signed [DATA_WIDTH-1:0] buf_q [WINDOW];

    // cnt_q is the write pointer in MODE 0 (equals the accepted-sample count
    // while in FILL) and the sample count in MODE 1. Both wrap at WINDOW-1.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data;

        sample_ext = {{LOG2W{in_data[DATA_WIDTH-1]}}, in_data};

        // sym_start restarts the window before this cycle's sample is applied,
        // so a coincident sample becomes sample 0 of the new window.
        if (sym_start) begin
            state_base = FILL;
            cnt_base   = '0;
            sum_base   = '0;
            oldest_ext = '0;
        end else begin
            state_base = state_q;
            cnt_base   = cnt_q;
            sum_base   = sum_q;
            oldest_ext = {{LOG2W{buf_q[cnt_q][DATA_WIDTH-1]}}, buf_q[cnt_q]};
        end

        last    = (cnt_base == LOG2W'(WINDOW - 1));
        sum_new = (MODE == 0) ? (sum_base + sample_ext - oldest_ext)
                              : (sum_base + sample_ext);

        state_d = state_base;
        cnt_d   = cnt_base;
        sum_d   = sum_base;

        if (in_valid) begin
            cnt_d = cnt_base + 1'b1;
            if (MODE == 0) begin
                sum_d = sum_new;
                if (state_base == RUN || last) begin
                    state_d     = RUN;
                    out_valid_d = 1'b1;
                    out_data_d  = sum_new;
                end
            end else begin
                if (last) begin
                    // Dump and restart on the same edge; cnt_d wraps to 0.
                    out_valid_d = 1'b1;
                    out_data_d  = sum_new;
                    sum_d       = '0;
                end else begin
                    sum_d = sum_new;
                end
            end
        end

        if (clear) begin
            state_d     = FILL;
            cnt_d       = '0;
            sum_d       = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            sum_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end

    // Sample history; only meaningful in MODE 0. Zeroing on restart makes the
    // "oldest" term zero throughout FILL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '{default: '0};
        end else if (clear) begin
            buf_q <= '{default: '0};
        end else begin
            if (sym_start) begin
                buf_q <= '{default: '0};
            end
            if (in_valid && MODE == 0) begin
                buf_q[cnt_base] <= in_data;
            end
        end
    end

endmodule

// File: doc/lpf_window_integrator.md
LPF_WINDOW_INTEGRATOR -- requirements
Module: lpf_window_integrator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18: signed two's-complement input sample width.
REQ-002 SHALL have parameter WINDOW, default 8: samples per sum; power of two, range 2..256.
REQ-003 SHALL have parameter MODE, default 0: 0 = sliding moving sum, 1 = integrate-and-dump.
REQ-004 SHALL have derived localparam OUT_WIDTH = DATA_WIDTH + log2(WINDOW).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1: in_data is a valid sample this cycle.
REQ-008 SHALL have port in_data, input, DATA_WIDTH: signed sample.
REQ-009 SHALL have port sym_start, input, 1: synchronous window restart (symbol-timing alignment).
REQ-010 SHALL have port clear, input, 1: synchronous flush of all state.
REQ-011 SHALL have port out_valid, output, 1: out_data holds a new sum; one-cycle pulse per result.
REQ-012 SHALL have port out_data, output, OUT_WIDTH: signed sum, registered.

Function
REQ-013 SHALL sum samples at full OUT_WIDTH precision, sign-extended; no saturation, rounding or scaling is needed because the width is sufficient.
REQ-014 SHALL ignore in_data when in_valid=0; no state changes except clear and sym_start.
REQ-015 Latency SHALL be 1 cycle: out_valid is asserted the cycle after the in_valid sample that completes a sum.
REQ-016 MODE 0 SHALL store the last WINDOW samples in a circular buffer (write pointer wraps at WINDOW-1 to 0) and hold a running sum updated as sum + new - oldest.
REQ-017 MODE 0 SHALL have states FILL and RUN; FILL counts accepted samples.
REQ-018 MODE 0 in FILL SHALL keep out_valid=0 and move to RUN on the WINDOW-th accepted sample, with out_valid asserted on the following cycle.
REQ-019 MODE 0 in RUN SHALL assert out_valid the cycle after every accepted sample.
REQ-020 MODE 1 SHALL accumulate accepted samples and count them.
REQ-021 MODE 1 on the WINDOW-th sample SHALL output the accumulator plus that sample next cycle with out_valid=1, and SHALL restart the accumulator and count at 0 in the same edge, so no sample is lost or double-counted.
REQ-022 sym_start=1 SHALL discard the partial window: MODE 1 zeroes the accumulator and count; MODE 0 zeroes the buffer and sum and returns to FILL. No out_valid results from the discarded window.
REQ-023 sym_start with in_valid in the same cycle SHALL count that sample as the first of the new window.
REQ-024 clear=1 SHALL have the same effect as reset on all state and outputs, synchronously; clear overrides sym_start and in_valid in the same cycle.
REQ-025 out_data SHALL hold its last value while out_valid=0.
REQ-026 There is no backpressure; the block SHALL accept one sample per cycle continuously.

Reset
REQ-027 rst_n=0 SHALL immediately clear out_valid to 0, out_data to 0, the sum or accumulator, all counters and pointers, and the buffer contents, and set the state to FILL.
REQ-028 The first accepted sample after rst_n deasserts SHALL be sample 0 of a fresh window.
REQ-029 Reset asserted mid-window SHALL discard the partial sum with no out_valid.

Verification (DATA_WIDTH=18, WINDOW=8)
REQ-030 MODE 0: samples k*1024 for k=0..7 on consecutive cycles -> out_valid is 0 for the first 8 output cycles, then pulses with out_data=28672.
REQ-031 MODE 0, continuing with sample 8*1024 -> out_data=36864 on the next cycle; buffer wrap-around is exercised.
REQ-032 MODE 1: 24 samples of 1024, in_valid gapped every third cycle -> exactly 3 out_valid pulses, each with out_data=8192.
REQ-033 MODE 1: 8 samples of -131072 -> out_data=-1048576, the OUT_WIDTH minimum, with no overflow; then 8 samples of 131071 -> 1048568.
REQ-034 MODE 1: 5 samples of 1024, then sym_start together with a sample of 100, then 7 samples of 100 -> single out_valid with out_data=800.
REQ-035 Either mode: rst_n pulsed low after 5 samples -> outputs are 0 asynchronously, no pulse occurs, and the next full window sums from scratch; clear gives the identical result one cycle late.
